// File: rtl/reg_dump_sequencer_pkg.sv
// Shared constants for the register-bank dump sequencer (state codes, word/byte sizing).
// DUMP_CYCLES includes the extra checksum byte when REG_DUMP_CHECKSUM_EN is defined.
package reg_dump_sequencer_pkg;

  localparam int DEF_NB_DATA    = 32;
  localparam int DEF_NB_ADDR    = 5;
  localparam int DEF_BANK_DEPTH = 32;
  localparam int DEF_NB_BYTE    = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // Counter width that stays legal even for a single-byte word.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BYTES_PER_WORD = DEF_NB_DATA / DEF_NB_BYTE;
  localparam int BYTE_CNT_W     = cnt_width(BYTES_PER_WORD);

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int DUMP_CYCLES = DEF_BANK_DEPTH * (2 + BYTES_PER_WORD) + 2;
`else
  localparam int DUMP_CYCLES = DEF_BANK_DEPTH * (2 + BYTES_PER_WORD) + 1;
`endif

endpackage

// File: rtl/reg_dump_serializer.sv
// Word-to-byte serializer: loads one register word and shifts it out MSB byte first
// under a valid/ready handshake; flags the acceptance of the word's last byte.
module reg_dump_serializer
  import reg_dump_sequencer_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_BYTE = DEF_NB_BYTE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [NB_DATA-1:0] data,
  input  logic               send,
  input  logic               tx_ready,
  output logic [NB_BYTE-1:0] tx_byte,
  output logic               accept,
  output logic               word_done
);

  localparam int BPW   = NB_DATA / NB_BYTE;
  localparam int CNT_W = cnt_width(BPW);

  logic [NB_DATA-1:0] shift;
  logic [CNT_W-1:0]   byte_cnt;

  assign tx_byte   = shift[NB_DATA-1 -: NB_BYTE];
  assign accept    = send & tx_ready;
  assign word_done = accept && (byte_cnt == CNT_W'(BPW - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shift    <= data;
      byte_cnt <= '0;
    end else if (accept) begin
      shift    <= shift << NB_BYTE;
      byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reg_dump_sequencer.sv
// Debug dump controller: walks the register bank read port and streams every word out bytewise.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
//
//   state | meaning
//   IDLE  | bank owned by pipeline, waiting for i_start
//   REQ   | read strobe for register index
//   WAIT  | bank data returns, captured into serializer
//   SEND  | bytes of the current word on the tx stream
//   CHK   | checksum byte on the tx stream (optional)
//   DONE  | one-cycle completion pulse
module reg_dump_sequencer
  import reg_dump_sequencer_pkg::*;
#(
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int NB_ADDR    = DEF_NB_ADDR,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int NB_BYTE    = DEF_NB_BYTE
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_bank_enable,
  output logic               o_read_enable,
  output logic [NB_ADDR-1:0] o_read_addr,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  logic [2:0]         state;
  logic [NB_ADDR-1:0] index;
  logic               in_send;
  logic               last_reg;
  logic               accept;
  logic               word_done;
  logic [NB_BYTE-1:0] ser_byte;

  assign in_send  = (state == ST_SEND);
  assign last_reg = (index == NB_ADDR'(BANK_DEPTH - 1));

  reg_dump_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .clock     (i_clock),
    .reset     (i_reset),
    .load      (state == ST_WAIT),
    .data      (i_reg_data),
    .send      (in_send),
    .tx_ready  (i_tx_ready),
    .tx_byte   (ser_byte),
    .accept    (accept),
    .word_done (word_done)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
      index <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state <= ST_REQ;
            index <= '0;
          end
        end
        ST_REQ:  state <= ST_WAIT;
        ST_WAIT: state <= ST_SEND;
        ST_SEND: begin
          if (word_done) begin
            if (last_reg) begin
`ifdef REG_DUMP_CHECKSUM_EN
              state <= ST_CHK;
`else
              state <= ST_DONE;
`endif
            end else begin
              index <= index + 1'b1;
              state <= ST_REQ;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        ST_CHK: begin
          if (i_tx_ready) state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
          index <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      csum <= '0;
    end else if (state == ST_IDLE && i_start) begin
      csum <= '0;
    end else if (accept) begin
      csum <= csum ^ ser_byte;
    end
  end

  assign o_tx_valid = in_send | (state == ST_CHK);
  assign o_tx_data  = (state == ST_CHK) ? csum : ser_byte;
`else
  assign o_tx_valid = in_send;
  assign o_tx_data  = ser_byte;
`endif

  // The pipeline loses the bank for the whole dump so no write-back can alter it.
  assign o_bank_enable = (state == ST_IDLE);
  assign o_read_enable = (state == ST_REQ);
  assign o_read_addr   = (state == ST_IDLE) ? '0 : index;
  assign o_busy        = (state != ST_IDLE);
  assign o_done        = (state == ST_DONE);

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Self-checking bench for reg_dump_sequencer: bank model, byte-stream reference built
// from bank contents, randomized ready patterns and bank data.
module tb_reg_dump_sequencer;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int EXP_BYTES = 129;
  localparam int DONE_CYC  = 194;
`else
  localparam int EXP_BYTES = 128;
  localparam int DONE_CYC  = 193;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        bank_enable;
  logic        read_enable;
  logic [4:0]  read_addr;
  logic [31:0] reg_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic        bank_write;
  logic [4:0]  bank_waddr;
  logic [31:0] bank_wdata;
  logic [31:0] mem [32];

  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];

  int passed = 0;
  int total  = 0;
  int done_cycle, done_count, en_err, stab_err, busy_after;
  bit timed_out;

  reg_dump_sequencer dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_start       (start),
    .o_bank_enable (bank_enable),
    .o_read_enable (read_enable),
    .o_read_addr   (read_addr),
    .i_reg_data    (reg_data),
    .o_tx_data     (tx_data),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .o_busy        (busy),
    .o_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank: registered read port, writes only when the pipeline owns it.
  always @(posedge clk) begin
    if (read_enable) reg_data <= mem[read_addr];
    if (bank_enable && bank_write) mem[bank_waddr] <= bank_wdata;
  end

  task automatic preload(input int mode);
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       mem[i] = 32'h0101_0101 * i;
        1:       mem[i] = i;
        default: mem[i] = $urandom;
      endcase
    end
  endtask

  // Reference stream: every word MSB byte first, optional XOR of all bytes at the end.
  task automatic build_expected();
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    for (int r = 0; r < 32; r++) begin
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(mem[r][8*b +: 8]);
        x = x ^ mem[r][8*b +: 8];
      end
    end
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  function automatic int first_diff();
    if (got.size() != exp_q.size())
      return (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    foreach (got[i]) if (got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Runs one dump; cycle n=1 is the first cycle after the start edge.
  task automatic do_dump(input int ready_mode, input bit poke_start, input bit poke_write);
    int n;
    bit prev_stall, poked;
    logic [7:0] prev_data;
    got.delete();
    done_cycle = -1; done_count = 0; en_err = 0; stab_err = 0; busy_after = 0; timed_out = 0;
    prev_stall = 0; poked = 0; prev_data = 8'h00;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (1) begin
      start = 1'b0;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = n[0];
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke_write) bank_write = (done_cycle < 0);
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stab_err++;
      prev_stall = (tx_valid === 1'b1) && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid === 1'b1 && tx_ready) got.push_back(tx_data);
      if (done === 1'b1) begin
        done_count++;
        if (done_cycle < 0) done_cycle = n;
        if (poke_start) start = 1'b1;
      end
      if (done_cycle >= 0 && n > done_cycle && busy !== 1'b0) busy_after++;
      if ((done_cycle < 0 || n == done_cycle) && bank_enable !== 1'b0) en_err++;
      if (poke_start && !poked && got.size() == 40) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (done_cycle >= 0 && n >= done_cycle + 6) break;
      if (n >= 3000) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; bank_write = 1'b0; tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (bank_enable !== 1'b1) $display("FAIL rst_bank_enable got=%b exp=1", bank_enable); else passed++;
    total++; if (read_enable !== 1'b0) $display("FAIL rst_read_enable got=%b exp=0", read_enable); else passed++;
    total++; if (read_addr !== 5'd0) $display("FAIL rst_read_addr got=%0d exp=0", read_addr); else passed++;
    total++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data got=%h exp=00", tx_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done got=%b exp=0", done); else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_basic();
    preload(0);
    build_expected();
    do_dump(0, 0, 0);
    total++; if (timed_out) $display("FAIL basic_timeout got=no done exp=done"); else passed++;
    total++; if (got.size() !== EXP_BYTES) $display("FAIL basic_len got=%0d exp=%0d", got.size(), EXP_BYTES); else passed++;
    total++; if (first_diff() != -1) $display("FAIL basic_stream first bad index got=%0d exp=none", first_diff()); else passed++;
    total++; if (done_cycle !== DONE_CYC) $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cycle, DONE_CYC); else passed++;
    total++; if (done_count !== 1) $display("FAIL basic_done_count got=%0d exp=1", done_count); else passed++;
    total++; if (en_err !== 0) $display("FAIL basic_bank_enable cycles high got=%0d exp=0", en_err); else passed++;
    total++; if (busy_after !== 0) $display("FAIL basic_busy_after got=%0d exp=0", busy_after); else passed++;
  endtask

  task automatic test_ready_toggle();
    preload(0);
    build_expected();
    do_dump(1, 0, 0);
    total++; if (first_diff() != -1) $display("FAIL toggle_stream first bad index got=%0d exp=none", first_diff()); else passed++;
    total++; if (stab_err !== 0) $display("FAIL toggle_stable got=%0d unstable stalls exp=0", stab_err); else passed++;
    total++; if (done_count !== 1) $display("FAIL toggle_done_count got=%0d exp=1", done_count); else passed++;
  endtask

  task automatic test_restart_ignored();
    preload(0);
    build_expected();
    do_dump(0, 1, 0);
    total++; if (got.size() !== EXP_BYTES) $display("FAIL restart_len got=%0d exp=%0d", got.size(), EXP_BYTES); else passed++;
    total++; if (done_count !== 1) $display("FAIL restart_done_count got=%0d exp=1", done_count); else passed++;
    total++; if (busy_after !== 0) $display("FAIL restart_busy_after got=%0d exp=0", busy_after); else passed++;
    total++; if (first_diff() != -1) $display("FAIL restart_stream first bad index got=%0d exp=none", first_diff()); else passed++;
  endtask

  task automatic test_async_reset();
    int n;
    preload(0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tx_ready = 1'b1;
    n = 0;
    while (!(tx_valid === 1'b1 && read_addr === 5'd7) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (n >= 400) $display("FAIL areset_reach_reg7 got=timeout exp=reg 7 in send"); else passed++;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++; if (bank_enable !== 1'b1) $display("FAIL areset_bank_enable got=%b exp=1", bank_enable); else passed++;
    total++; if (read_addr !== 5'd0) $display("FAIL areset_read_addr got=%0d exp=0", read_addr); else passed++;
    total++; if (tx_valid !== 1'b0) $display("FAIL areset_tx_valid got=%b exp=0", tx_valid); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL areset_tx_data got=%h exp=00", tx_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL areset_busy got=%b exp=0", busy); else passed++;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    build_expected();
    do_dump(0, 0, 0);
    total++; if (first_diff() != -1) $display("FAIL areset_redump first bad index got=%0d exp=none", first_diff()); else passed++;
    total++; if (done_cycle !== DONE_CYC) $display("FAIL areset_done_cycle got=%0d exp=%0d", done_cycle, DONE_CYC); else passed++;
  endtask

  task automatic test_write_during_dump();
    preload(0);
    build_expected();
    bank_waddr = 5'd3;
    bank_wdata = 32'hFFFF_FFFF;
    do_dump(0, 0, 1);
    total++; if (first_diff() != -1) $display("FAIL write_stream first bad index got=%0d exp=none", first_diff()); else passed++;
    total++; if (mem[3] !== 32'h0303_0303) $display("FAIL write_reg3 got=%h exp=03030303", mem[3]); else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      preload(2);
      build_expected();
      do_dump(2, 0, 0);
      total++; if (timed_out) $display("FAIL random_timeout it=%0d got=no done exp=done", it); else passed++;
      total++; if (first_diff() != -1) $display("FAIL random_stream it=%0d first bad index got=%0d exp=none", it, first_diff()); else passed++;
      total++; if (stab_err !== 0) $display("FAIL random_stable it=%0d got=%0d exp=0", it, stab_err); else passed++;
      total++; if (done_count !== 1) $display("FAIL random_done_count it=%0d got=%0d exp=1", it, done_count); else passed++;
    end
  endtask

`ifdef REG_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    preload(1);
    do_dump(0, 0, 0);
    total++; if (got.size() !== 129) $display("FAIL csum_len got=%0d exp=129", got.size()); else passed++;
    total++; if (got.size() < 129 || got[128] !== 8'h00) $display("FAIL csum_zero got=%h exp=00", (got.size() > 128) ? got[128] : 8'hxx); else passed++;
    mem[0] = 32'h0000_00A5;
    do_dump(0, 0, 0);
    total++; if (got.size() < 129 || got[128] !== 8'hA5) $display("FAIL csum_a5 got=%h exp=a5", (got.size() > 128) ? got[128] : 8'hxx); else passed++;
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1;
    bank_write = 1'b0; bank_waddr = 5'd0; bank_wdata = 32'h0;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_restart_ignored();
    test_async_reset();
    test_write_during_dump();
    test_random();
`ifdef REG_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
